glitch_fifo_sc: RTL and testbench
=================================

Name: glitch_fifo_sc

Overview:
Parametrised single-clock FIFO that succeeds the fixed 48x256 glitch FIFO. It buffers glitch-parameter words between the capture/sequencer logic and the host readout path. Width and depth are generics. It adds a first-word-fall-through (FWFT) mode, runtime-programmable almost-full/almost-empty thresholds, a fill-level output, a synchronous flush, and sticky overflow/underflow flags.

Parameters:
WIDTH, 48, data word width in bits (1..128)
ADDR, 8, log2 of depth; DEPTH = 2**ADDR words
FWFT, 0, 0 = standard read (Q valid 1 cycle after accepted RE); 1 = first-word-fall-through

Ports:
CLOCK  in  1  single clock; all state updates on rising edge
RESETN  in  1  asynchronous, active-low reset
CLR  in  1  synchronous flush, active-high
DATA  in  WIDTH  write data
WE  in  1  write request, active-high
RE  in  1  read request / pop, active-high
AFVAL  in  ADDR+1  almost-full threshold, in words
AEVAL  in  ADDR+1  almost-empty threshold, in words
Q  out  WIDTH  read data, registered
FULL  out  1  LEVEL == DEPTH
EMPTY  out  1  standard: LEVEL == 0; FWFT: Q not valid
AFULL  out  1  LEVEL >= AFVAL
AEMPTY  out  1  LEVEL <= AEVAL
LEVEL  out  ADDR+1  accepted, unpopped words (0..DEPTH)
OVERFLOW  out  1  sticky: write attempted while FULL
UNDERFLOW  out  1  sticky: read attempted while EMPTY

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. The clock port is CLOCK and the reset port is RESETN.
- Reset (RESETN=0, immediate, no clock needed):
  - LEVEL=0, FULL=0, EMPTY=1, Q=0, OVERFLOW=0, UNDERFLOW=0.
  - Read/write pointers = 0.
  - AFULL/AEMPTY follow their compare rules; with LEVEL=0, AEMPTY=1 and AFULL=(AFVAL==0).
- Reset release: synchronise internally so the first active edge is clean.
- Accept rules (evaluated on registered flags):
  - wr_ok = WE & ~FULL.
  - rd_ok = RE & ~EMPTY.
  - WE & FULL: no write; OVERFLOW<=1.
  - RE & EMPTY: no pop; UNDERFLOW<=1.
  - Gating uses the pre-edge flags, so when FULL a simultaneous RE does not enable the write, and when EMPTY a simultaneous WE does not enable the read.
- LEVEL update, per edge:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - unchanged when both or neither are accepted.
- Pointers:
  - Binary, ADDR bits, wrap DEPTH-1 -> 0 naturally.
  - FULL/EMPTY derive from LEVEL, never from pointer equality.
- Flags:
  - FULL and standard-mode EMPTY are registered, updated the same edge as LEVEL.
  - AFULL/AEMPTY are combinational compares of the LEVEL register against the AFVAL/AEVAL ports. A threshold change takes effect without an edge.
- Standard mode (FWFT=0):
  - Q loads mem[rptr] on the edge where rd_ok; read latency 1 edge.
  - Q holds its value otherwise.
  - Storage is a DEPTH x WIDTH synchronous RAM, inferable as block RAM.
- FWFT mode (FWFT=1):
  - An output register holds the head word; EMPTY=0 whenever the output register is valid.
  - A write into an empty FIFO on edge k makes Q valid and EMPTY=0 after edge k+1 (RAM read-ahead cycle).
  - rd_ok on edge k: the next word, if present, is on Q after edge k; otherwise EMPTY=1 after edge k.
  - LEVEL counts the output register word plus RAM contents. Total capacity stays DEPTH.
  - LEVEL may be 1 while EMPTY=1 during the read-ahead cycle.
- CLR (synchronous, priority over WE/RE):
  - Next edge: pointers=0, LEVEL=0, FULL=0, EMPTY=1, Q=0, OVERFLOW=0, UNDERFLOW=0.
  - Any same-cycle write or read is discarded.
- Sticky flags clear only by RESETN or CLR.
- RAM contents are not cleared by reset; data is only observable after being written.
- No X propagation on Q after reset, including FWFT before the first write.

Test Plan:
- Reset, AFVAL=255, AEVAL=1, FWFT=0; write 0..255 on consecutive edges -> AEMPTY falls after the 2nd write edge; AFULL rises after the 255th; FULL=1 and LEVEL=256 after the 256th.
- From full, assert WE with DATA=0xDEAD for 1 cycle -> OVERFLOW=1, LEVEL stays 256. Then RE for 256 cycles -> Q = 0..255, each 1 edge after its RE; EMPTY=1 at the end; 0xDEAD is never output.
- At LEVEL=10, hold WE=RE=1 for 5 cycles -> LEVEL stays 10, FIFO order preserved. At LEVEL=0 with WE=RE=1 -> one word stored, LEVEL=1, UNDERFLOW=1.
- FWFT=1: write 0xABC to an empty FIFO on edge k -> after edge k+1, EMPTY=0 and Q=0xABC with RE=0. Pulse RE -> EMPTY=1 next edge, LEVEL=0.
- Pointer wrap: write and read 300 words interleaved at LEVEL ~128 -> output sequence matches the input exactly across the wrap, no flag glitch.
- CLR with WE=1 at LEVEL=40 and OVERFLOW=1 -> next edge LEVEL=0, EMPTY=1, OVERFLOW=0, write discarded. RESETN low mid-burst with no clock -> all outputs reach reset values immediately.

Source files
------------

// File: rtl/glitch_fifo_sc.sv
// Parametrised single-clock glitch FIFO.
// Standard or first-word-fall-through read, level, thresholds, sticky flags.
module glitch_fifo_sc #(
  parameter int WIDTH = 48,
  parameter int ADDR  = 8,
  parameter bit FWFT  = 1'b0
) (
  input  logic             CLOCK,
  input  logic             RESETN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DATA,
  input  logic             WE,
  input  logic             RE,
  input  logic [ADDR:0]    AFVAL,
  input  logic [ADDR:0]    AEVAL,
  output logic [WIDTH-1:0] Q,
  output logic             FULL,
  output logic             EMPTY,
  output logic             AFULL,
  output logic             AEMPTY,
  output logic [ADDR:0]    LEVEL,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  localparam int DEPTH = 2 ** ADDR;
  localparam logic [ADDR:0] DEPTH_L =
    {1'b1, {ADDR{1'b0}}};

  logic [1:0]       sync_q;
  logic             run;
  logic             wr_ok;
  logic             rd_ok;
  logic [ADDR:0]    level_q;
  logic [ADDR:0]    level_d;
  logic             full_q;
  logic             full_d;
  logic             empty_q;
  logic             empty_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             unf_q;
  logic             unf_d;
  logic [ADDR-1:0]  wptr_q;
  logic [ADDR-1:0]  wptr_d;
  logic [ADDR-1:0]  rptr_q;
  logic [ADDR-1:0]  rptr_d;
  logic [WIDTH-1:0] q_q;

  // Reset asserts at once but releases only after two clean edges
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign run = sync_q[1];

  assign wr_ok = run & ~CLR & WE & ~full_q;
  assign rd_ok = run & ~CLR & RE & ~empty_q;

  always_comb begin
    level_d = level_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (CLR) begin
      level_d = '0;
    end
  end

  assign full_d = (level_d == DEPTH_L);

  always_comb begin
    wptr_d = wptr_q;
    if (CLR) begin
      wptr_d = '0;
    end else if (wr_ok) begin
      wptr_d = wptr_q + 1'b1;
    end
  end

  always_comb begin
    ovf_d = ovf_q | (run & WE & full_q);
    unf_d = unf_q | (run & RE & empty_q);
    if (CLR) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  if (FWFT) begin : g_fwft
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] dout_q;
    logic [ADDR:0]    ram_cnt;
    logic             ld;

    // LEVEL includes the output register word; the rest lives in RAM
    assign ram_cnt = level_q - {{ADDR{1'b0}}, ~empty_q};
    assign ld = ~CLR & (empty_q | rd_ok) & (ram_cnt != '0);

    always_comb begin
      rptr_d = rptr_q;
      if (CLR) begin
        rptr_d = '0;
      end else if (ld) begin
        rptr_d = rptr_q + 1'b1;
      end
    end

    always_comb begin
      empty_d = empty_q;
      if (CLR) begin
        empty_d = 1'b1;
      end else if (ld) begin
        empty_d = 1'b0;
      end else if (rd_ok) begin
        empty_d = 1'b1;
      end
    end

    // Read-ahead port tracks the next head; write-first on collision
    always_ff @(posedge CLOCK) begin
      if (wr_ok) begin
        mem[wptr_q] <= DATA;
      end
      if (wr_ok && (wptr_q == rptr_d)) begin
        dout_q <= DATA;
      end else begin
        dout_q <= mem[rptr_d];
      end
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN) begin
        q_q <= '0;
      end else if (CLR) begin
        q_q <= '0;
      end else if (ld) begin
        q_q <= dout_q;
      end
    end
  end else begin : g_std
    logic [WIDTH-1:0] mem [DEPTH];

    always_comb begin
      rptr_d = rptr_q;
      if (CLR) begin
        rptr_d = '0;
      end else if (rd_ok) begin
        rptr_d = rptr_q + 1'b1;
      end
    end

    assign empty_d = (level_d == '0);

    always_ff @(posedge CLOCK) begin
      if (wr_ok) begin
        mem[wptr_q] <= DATA;
      end
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN) begin
        q_q <= '0;
      end else if (CLR) begin
        q_q <= '0;
      end else if (rd_ok) begin
        q_q <= mem[rptr_q];
      end
    end
  end

  assign Q         = q_q;
  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign LEVEL     = level_q;
  assign AFULL     = (level_q >= AFVAL);
  assign AEMPTY    = (level_q <= AEVAL);
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_glitch_fifo_sc.sv
// Directed bench for glitch_fifo_sc.
// Standard and FWFT instances share one stimulus stream.
module tb_glitch_fifo_sc;

  localparam int W = 48;
  localparam int A = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         clr = 1'b0;
  logic         we = 1'b0;
  logic         re = 1'b0;
  logic [W-1:0] data = '0;
  logic [A:0]   afval = 9'd255;
  logic [A:0]   aeval = 9'd1;

  logic [W-1:0] s_q, f_q;
  logic         s_full, s_empty, s_afull, s_aempty;
  logic         f_full, f_empty, f_afull, f_aempty;
  logic [A:0]   s_level, f_level;
  logic         s_ovf, s_unf, f_ovf, f_unf;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  glitch_fifo_sc #(.WIDTH(W), .ADDR(A), .FWFT(1'b0)) u_std (
    .CLOCK(clk), .RESETN(rstn), .CLR(clr), .DATA(data),
    .WE(we), .RE(re), .AFVAL(afval), .AEVAL(aeval),
    .Q(s_q), .FULL(s_full), .EMPTY(s_empty),
    .AFULL(s_afull), .AEMPTY(s_aempty), .LEVEL(s_level),
    .OVERFLOW(s_ovf), .UNDERFLOW(s_unf)
  );

  glitch_fifo_sc #(.WIDTH(W), .ADDR(A), .FWFT(1'b1)) u_fw (
    .CLOCK(clk), .RESETN(rstn), .CLR(clr), .DATA(data),
    .WE(we), .RE(re), .AFVAL(afval), .AEVAL(aeval),
    .Q(f_q), .FULL(f_full), .EMPTY(f_empty),
    .AFULL(f_afull), .AEMPTY(f_aempty), .LEVEL(f_level),
    .OVERFLOW(f_ovf), .UNDERFLOW(f_unf)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rstn = 1'b0;
    #1;
    chk("rst_level", 64'(s_level), 0);
    chk("rst_full", 64'(s_full), 0);
    chk("rst_empty", 64'(s_empty), 1);
    chk("rst_q", 64'(s_q), 0);
    chk("rst_ovf", 64'(s_ovf), 0);
    chk("rst_unf", 64'(s_unf), 0);
    chk("rst_aempty", 64'(s_aempty), 1);
    chk("rst_afull", 64'(s_afull), 0);
    chk("rst_f_empty", 64'(f_empty), 1);
    chk("rst_f_q", 64'(f_q), 0);

    tick;
    rstn = 1'b1;
    tick;
    tick;

    // fill 0..255
    for (int i = 0; i < 256; i++) begin
      data = W'(i);
      we = 1'b1;
      tick;
      if (i == 0) begin
        chk("fill_aempty1", 64'(s_aempty), 1);
        chk("fw_readahead_empty", 64'(f_empty), 1);
        chk("fw_readahead_level", 64'(f_level), 1);
      end
      if (i == 1) begin
        chk("fill_aempty2", 64'(s_aempty), 0);
        chk("fw_first_empty", 64'(f_empty), 0);
        chk("fw_first_q", 64'(f_q), 0);
      end
      if (i == 253) chk("fill_afull254", 64'(s_afull), 0);
      if (i == 254) begin
        chk("fill_afull255", 64'(s_afull), 1);
        chk("fill_full255", 64'(s_full), 0);
      end
    end
    chk("full_flag", 64'(s_full), 1);
    chk("full_level", 64'(s_level), 256);
    chk("fw_full_flag", 64'(f_full), 1);
    chk("fw_full_level", 64'(f_level), 256);

    data = 48'hDEAD;
    we = 1'b1;
    tick;
    we = 1'b0;
    chk("ovf_flag", 64'(s_ovf), 1);
    chk("ovf_level", 64'(s_level), 256);
    chk("fw_ovf_flag", 64'(f_ovf), 1);

    re = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick;
      chk("drain_q", 64'(s_q), 64'(i));
      if (i < 255) chk("fw_drain_q", 64'(f_q), 64'(i + 1));
    end
    re = 1'b0;
    chk("drain_empty", 64'(s_empty), 1);
    chk("drain_level", 64'(s_level), 0);
    chk("fw_drain_empty", 64'(f_empty), 1);
    chk("drain_unf", 64'(s_unf), 0);

    // level 10 with simultaneous read and write
    we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data = W'(100 + i);
      tick;
    end
    chk("l10_level", 64'(s_level), 10);
    re = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = W'(110 + i);
      tick;
      chk("rw_q", 64'(s_q), 64'(100 + i));
      chk("rw_level", 64'(s_level), 10);
      chk("fw_rw_level", 64'(f_level), 10);
    end
    we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("rw_tail_q", 64'(s_q), 64'(105 + i));
    end
    re = 1'b0;
    chk("rw_end_level", 64'(s_level), 0);

    // WE=RE at empty
    we = 1'b1;
    re = 1'b1;
    data = 48'h77;
    tick;
    we = 1'b0;
    re = 1'b0;
    chk("e_rw_level", 64'(s_level), 1);
    chk("e_rw_unf", 64'(s_unf), 1);
    chk("e_rw_q_hold", 64'(s_q), 114);
    re = 1'b1;
    tick;
    re = 1'b0;
    chk("e_rw_q", 64'(s_q), 64'h77);
    chk("e_rw_level2", 64'(s_level), 0);
    chk("fw_e_rw_level", 64'(f_level), 1);
    chk("fw_e_rw_empty", 64'(f_empty), 0);
    chk("fw_e_rw_q", 64'(f_q), 64'h77);

    clr = 1'b1;
    we = 1'b1;
    data = 48'h1;
    tick;
    clr = 1'b0;
    we = 1'b0;
    chk("clr_level", 64'(s_level), 0);
    chk("clr_empty", 64'(s_empty), 1);
    chk("clr_q", 64'(s_q), 0);
    chk("clr_unf", 64'(s_unf), 0);
    chk("fw_clr_level", 64'(f_level), 0);
    chk("fw_clr_empty", 64'(f_empty), 1);
    chk("fw_clr_q", 64'(f_q), 0);
    chk("fw_clr_unf", 64'(f_unf), 0);

    // FWFT latency
    data = 48'hABC;
    we = 1'b1;
    tick;
    we = 1'b0;
    chk("fw_k_empty", 64'(f_empty), 1);
    chk("fw_k_level", 64'(f_level), 1);
    tick;
    chk("fw_k1_empty", 64'(f_empty), 0);
    chk("fw_k1_q", 64'(f_q), 64'hABC);
    re = 1'b1;
    tick;
    re = 1'b0;
    chk("fw_pop_empty", 64'(f_empty), 1);
    chk("fw_pop_level", 64'(f_level), 0);
    chk("std_abc_q", 64'(s_q), 64'hABC);

    // pointer wrap at level 128
    we = 1'b1;
    for (int n = 0; n < 128; n++) begin
      data = W'(1000 + n);
      tick;
    end
    chk("wrap_level", 64'(s_level), 128);
    re = 1'b1;
    for (int j = 0; j < 300; j++) begin
      data = W'(1128 + j);
      tick;
      chk("wrap_q", 64'(s_q), 64'(1000 + j));
      chk("wrap_lvl", 64'(s_level), 128);
      chk("wrap_flags",
          64'({s_full, s_empty, s_afull, s_aempty}), 0);
      chk("fw_wrap_q", 64'(f_q), 64'(1001 + j));
      chk("fw_wrap_flags",
          64'({f_full, f_empty, f_afull, f_aempty}), 0);
    end
    re = 1'b0;

    // clear at level 40 with overflow pending
    for (int n = 0; n < 128; n++) begin
      data = W'(n);
      tick;
    end
    chk("refill_full", 64'(s_full), 1);
    tick;
    we = 1'b0;
    chk("refill_ovf", 64'(s_ovf), 1);
    re = 1'b1;
    for (int n = 0; n < 216; n++) tick;
    re = 1'b0;
    chk("l40_level", 64'(s_level), 40);
    chk("l40_ovf", 64'(s_ovf), 1);
    clr = 1'b1;
    we = 1'b1;
    data = 48'hBEEF;
    tick;
    clr = 1'b0;
    we = 1'b0;
    chk("clr40_level", 64'(s_level), 0);
    chk("clr40_empty", 64'(s_empty), 1);
    chk("clr40_ovf", 64'(s_ovf), 0);
    chk("clr40_full", 64'(s_full), 0);
    chk("clr40_q", 64'(s_q), 0);
    re = 1'b1;
    tick;
    re = 1'b0;
    chk("clr40_unf", 64'(s_unf), 1);
    chk("clr40_discard_lvl", 64'(s_level), 0);
    chk("clr40_discard_q", 64'(s_q), 0);

    // async reset mid-burst
    we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = W'(500 + i);
      tick;
    end
    re = 1'b1;
    data = 48'd505;
    tick;
    chk("burst_q", 64'(s_q), 500);
    chk("burst_level", 64'(s_level), 5);
    #2 rstn = 1'b0;
    #1;
    chk("arst_level", 64'(s_level), 0);
    chk("arst_full", 64'(s_full), 0);
    chk("arst_empty", 64'(s_empty), 1);
    chk("arst_q", 64'(s_q), 0);
    chk("arst_ovf", 64'(s_ovf), 0);
    chk("arst_unf", 64'(s_unf), 0);
    chk("arst_aempty", 64'(s_aempty), 1);
    chk("fw_arst_level", 64'(f_level), 0);
    chk("fw_arst_empty", 64'(f_empty), 1);
    chk("fw_arst_q", 64'(f_q), 0);
    we = 1'b0;
    re = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
